// File: rtl/fixed_power.sv
// Iterative unsigned Q10.10 power unit: out = base ^ exponent, one truncating multiply per clock.
// Define FIXED_POWER_ROUND_EN to make every multiply round half-up instead of truncating.
module fixed_power #(
  parameter int WIDTH     = 20,
  parameter int FRAC_BITS = 10,
  parameter int EXP_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [EXP_W-1:0] in_data_2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC_BITS;
  localparam logic [WIDTH-1:0] SAT_VAL = '1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    OUT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] base, base_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [EXP_W-1:0] exponent, exponent_next;
  logic [EXP_W-1:0] cnt, cnt_next, cnt_inc;
  logic             sat, sat_next;
  logic             out_valid_next;
  logic [WIDTH-1:0] out_data_next;
  logic             out_overflow_next;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    q;
  logic             mul_ovf;

  // Full-width product, rescaled back to Q10.10; any bit above WIDTH means overflow.
  always_comb begin
    prod = PW'(acc) * PW'(base);
`ifdef FIXED_POWER_ROUND_EN
    q = (prod + (PW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
`else
    q = prod >> FRAC_BITS;
`endif
    mul_ovf = |q[PW-1:WIDTH];
    cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      acc          <= '0;
      exponent     <= '0;
      cnt          <= '0;
      sat          <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      base         <= base_next;
      acc          <= acc_next;
      exponent     <= exponent_next;
      cnt          <= cnt_next;
      sat          <= sat_next;
      out_valid    <= out_valid_next;
      out_data     <= out_data_next;
      out_overflow <= out_overflow_next;
    end
  end

  always_comb begin
    state_next        = state;
    base_next         = base;
    acc_next          = acc;
    exponent_next     = exponent;
    cnt_next          = cnt;
    sat_next          = sat;
    out_valid_next    = 1'b0;
    out_data_next     = '0;
    out_overflow_next = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          base_next     = in_data_1;
          exponent_next = in_data_2;
          acc_next      = ONE;
          cnt_next      = '0;
          sat_next      = 1'b0;
          state_next    = (in_data_2 != '0) ? MUL : OUT;
        end
      end
      MUL: begin
        // Saturation is sticky: once set, later factors (even zero) cannot clear it.
        if (mul_ovf || sat) begin
          acc_next = SAT_VAL;
          sat_next = 1'b1;
        end else begin
          acc_next = q[WIDTH-1:0];
        end
        cnt_next = cnt_inc;
        if (cnt_inc == exponent) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid_next    = 1'b1;
        out_data_next     = acc;
        out_overflow_next = sat;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
